// File: rtl/conv_encoder_punct_pkg.sv
// Shared 802.11a encoder definitions: rate codes, default generators and puncture masks.
package conv_encoder_punct_pkg;

  typedef enum logic [1:0] {
    RATE_1_2  = 2'b00,
    RATE_2_3  = 2'b01,
    RATE_3_4  = 2'b10,
    RATE_RSVD = 2'b11
  } rate_e;

  localparam int unsigned DEF_K  = 7;
  localparam logic [6:0]  DEF_G0 = 7'o133;
  localparam logic [6:0]  DEF_G1 = 7'o171;

  // Which mother-code bits survive puncturing in a given phase.
  typedef struct packed {
    logic push_a;
    logic push_b;
  } punct_t;

  function automatic rate_e rate_decode(input logic [1:0] code);
    return (code == RATE_RSVD) ? RATE_1_2 : rate_e'(code);
  endfunction

  function automatic logic [1:0] punct_last_phase(input rate_e r);
    case (r)
      RATE_2_3: return 2'd1;
      RATE_3_4: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

  function automatic punct_t punct_mask(input rate_e r, input logic [1:0] phase);
    punct_t m;
    m = '{push_a: 1'b1, push_b: 1'b1};
    if ((r == RATE_2_3 || r == RATE_3_4) && phase == 2'd1) m.push_b = 1'b0;
    if (r == RATE_3_4 && phase == 2'd2) m.push_a = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/conv_encoder_punct_coded_bit_fifo.sv
// Bit FIFO taking up to two writes and one read per cycle; wr_bits[0] is written first.
module coded_bit_fifo #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [1:0]    wr_n,
  input  logic [1:0]    wr_bits,
  input  logic          rd,
  output logic          head,
  output logic [LW-1:0] level
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_1;
  logic [LW-1:0]    free;
  logic             rd_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wr_ptr_1 = ptr_inc(wr_ptr);
  assign rd_en    = rd && (level != '0);
  assign free     = LW'(DEPTH) - level;
  assign head     = (level != '0) && mem[rd_ptr];

  // NOTE: storage has no reset; head is masked by level, so stale contents never reach the port.
  always_ff @(posedge clk) begin
    if (!clr) begin
      if (wr_n != 2'd0) mem[wr_ptr]   <= wr_bits[0];
      if (wr_n == 2'd2) mem[wr_ptr_1] <= wr_bits[1];
    end
  end

  // NOTE: non-blocking assignments make every register sample pre-edge values, independent of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_n == 2'd1)      wr_ptr <= wr_ptr_1;
      else if (wr_n == 2'd2) wr_ptr <= ptr_inc(wr_ptr_1);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      level <= level + LW'(wr_n) - LW'(rd_en);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) (clr || (LW'(wr_n) <= free)));

endmodule

// File: rtl/conv_encoder_punct.sv
// 802.11a rate-1/2 convolutional encoder with runtime puncturing to 2/3 or 3/4,
// feeding a small output FIFO that absorbs the 2:1 expansion.
module conv_encoder_punct
  import conv_encoder_punct_pkg::*;
#(
  parameter int unsigned  K          = DEF_K,
  parameter logic [K-1:0] G0         = K'(DEF_G0),
  parameter logic [K-1:0] G1         = K'(DEF_G1),
  parameter int unsigned  FIFO_DEPTH = 4,
  parameter int unsigned  CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       rate,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_bit,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] out_count
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);

  logic [K-2:0]  state;
  logic [1:0]    phase;
  rate_e         rate_q;
  logic [LW-1:0] level, free;
  logic [K-1:0]  w;
  logic          accept, pop, coded_a, coded_b, head;
  punct_t        mask;
  logic [1:0]    wr_n, wr_bits;

  // Two free slots guarantee room for a full A/B pair regardless of a concurrent pop.
  assign free      = LW'(FIFO_DEPTH) - level;
  assign in_ready  = !rst && !start && (free >= LW'(2));
  assign accept    = in_valid && in_ready;
  assign out_valid = (level != '0);
  assign out_bit   = head;
  assign busy      = out_valid;
  assign pop       = out_valid && out_ready && !start;

  assign w       = {in_bit, state};
  assign coded_a = ^(w & G0);
  assign coded_b = ^(w & G1);
  assign mask    = punct_mask(rate_q, phase);

  // NOTE: outputs get defaults before any branch, so no path through always_comb infers a latch.
  always_comb begin
    wr_n    = 2'd0;
    wr_bits = 2'b00;
    if (accept) begin
      if (mask.push_a && mask.push_b) begin
        wr_n    = 2'd2;
        wr_bits = {coded_b, coded_a};
      end else if (mask.push_a) begin
        wr_n    = 2'd1;
        wr_bits = {1'b0, coded_a};
      end else if (mask.push_b) begin
        wr_n    = 2'd1;
        wr_bits = {1'b0, coded_b};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= '0;
      phase     <= 2'd0;
      rate_q    <= RATE_1_2;
      out_count <= '0;
    end else if (start) begin
      state     <= '0;
      phase     <= 2'd0;
      rate_q    <= rate_decode(rate);
      out_count <= '0;
    end else begin
      if (accept) begin
        state <= w[K-1:1];
        phase <= (phase == punct_last_phase(rate_q)) ? 2'd0 : phase + 2'd1;
      end
      if (pop) out_count <= out_count + 1'b1;
    end
  end

  coded_bit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (start),
    .wr_n    (wr_n),
    .wr_bits (wr_bits),
    .rd      (pop),
    .head    (head),
    .level   (level)
  );

endmodule

// File: tb/tb_conv_encoder_punct.sv
// Self-checking bench for conv_encoder_punct: directed scenarios plus random packets
// against a tap-sum / keep-pattern reference model.
module tb_conv_encoder_punct;

  localparam int K      = 7;
  localparam int BUDGET = 6000;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_bit, in_ready;
  logic        out_valid, out_bit, out_ready, busy;
  logic [1:0]  rate;
  logic [15:0] out_count;

  int n_cmp = 0;
  int n_err = 0;

  bit src_q[$], sent_q[$], got_q[$], exp_q[$];

  always #5 clk = ~clk;

  conv_encoder_punct dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rate      (rate),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .out_ready (out_ready),
    .busy      (busy),
    .out_count (out_count)
  );

  // Sample handshakes mid-cycle, then advance to just after the next rising edge.
  task automatic cycle();
    #1;
    if (in_valid && in_ready) begin
      sent_q.push_back(in_bit);
      if (src_q.size() != 0) void'(src_q.pop_front());
    end
    if (out_valid && out_ready) got_q.push_back(out_bit);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] r);
    start = 1'b1;
    rate  = r;
    cycle();
    start = 1'b0;
    rate  = 2'($urandom_range(3));
    sent_q.delete();
    got_q.delete();
  endtask

  task automatic drive(input int exp_pops, input int vld_pct, input int rdy_pct, input string tag);
    int cyc = 0;
    while ((src_q.size() != 0 || got_q.size() < exp_pops) && cyc < BUDGET) begin
      in_valid  = (src_q.size() != 0) && ($urandom_range(99) < vld_pct);
      in_bit    = (src_q.size() != 0) ? src_q[0] : 1'b0;
      out_ready = ($urandom_range(99) < rdy_pct);
      cycle();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (cyc >= BUDGET) begin
      n_err++;
      $display("FAIL %s timeout: popped %0d bits, required %0d", tag, got_q.size(), exp_pops);
    end
  endtask

  // Reference: each coded bit is a parity over the last K inputs; puncturing keeps
  // selected positions of the mother stream A0 B0 A1 B1 ... within one period.
  task automatic build_expected(input logic [1:0] r);
    int       p;
    bit [5:0] keep;
    bit [6:0] g0v, g1v;
    bit       a, b, u;
    g0v = 7'o133;
    g1v = 7'o171;
    case (r)
      2'b01:   begin p = 2; keep = 6'b000111; end
      2'b10:   begin p = 3; keep = 6'b100111; end
      default: begin p = 1; keep = 6'b000011; end
    endcase
    exp_q.delete();
    for (int n = 0; n < sent_q.size(); n++) begin
      a = 1'b0;
      b = 1'b0;
      for (int i = 0; i < K; i++) begin
        u = (n - i >= 0) ? sent_q[n-i] : 1'b0;
        a ^= g0v[K-1-i] & u;
        b ^= g1v[K-1-i] & u;
      end
      if (keep[2*(n%p)])   exp_q.push_back(a);
      if (keep[2*(n%p)+1]) exp_q.push_back(b);
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp += 5;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b, want 0", out_valid); end
    if (out_bit !== 1'b0)   begin n_err++; $display("FAIL reset out_bit: got %b, want 0", out_bit); end
    if (busy !== 1'b0)      begin n_err++; $display("FAIL reset busy: got %b, want 0", busy); end
    if (in_ready !== 1'b0)  begin n_err++; $display("FAIL reset in_ready: got %b, want 0", in_ready); end
    if (out_count !== 16'd0) begin n_err++; $display("FAIL reset out_count: got %0d, want 0", out_count); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL post-reset in_ready: got %b, want 1", in_ready); end
  endtask

  task automatic test_impulse();
    bit [13:0] golden;
    golden = 14'b11_01_11_11_00_10_11;
    pulse_start(2'b00);
    src_q = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    drive(14, 100, 100, "impulse");
    n_cmp++;
    if (got_q.size() != 14) begin n_err++; $display("FAIL impulse length: got %0d, want 14", got_q.size()); end
    for (int i = 0; i < 14 && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== golden[13-i]) begin
        n_err++; $display("FAIL impulse bit %0d: got %b, want %b", i, got_q[i], golden[13-i]);
      end
    end
    n_cmp++;
    if (out_count !== 16'd14) begin n_err++; $display("FAIL impulse out_count: got %0d, want 14", out_count); end
  endtask

  task automatic test_punct();
    bit [3:0] g34;
    bit [4:0] g23;
    g34 = 4'b1101;
    g23 = 5'b11011;
    // Latency: first coded bit visible the cycle after acceptance.
    pulse_start(2'b10);
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    out_ready = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL latency pre out_valid: got %b, want 0", out_valid); end
    cycle();
    in_valid = 1'b0;
    n_cmp += 2;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL latency out_valid: got %b, want 1", out_valid); end
    if (out_bit !== 1'b1)   begin n_err++; $display("FAIL latency out_bit: got %b, want 1", out_bit); end
    src_q = '{1'b0, 1'b0};
    drive(4, 100, 100, "rate34");
    n_cmp++;
    if (got_q.size() != 4) begin n_err++; $display("FAIL rate34 length: got %0d, want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== g34[3-i]) begin n_err++; $display("FAIL rate34 bit %0d: got %b, want %b", i, got_q[i], g34[3-i]); end
    end
    pulse_start(2'b01);
    src_q = '{1'b1, 1'b0, 1'b0};
    drive(5, 100, 100, "rate23");
    n_cmp += 2;
    if (got_q.size() != 5)   begin n_err++; $display("FAIL rate23 length: got %0d, want 5", got_q.size()); end
    if (out_count !== 16'd5) begin n_err++; $display("FAIL rate23 out_count: got %0d, want 5", out_count); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== g23[4-i]) begin n_err++; $display("FAIL rate23 bit %0d: got %b, want %b", i, got_q[i], g23[4-i]); end
    end
  endtask

  task automatic test_backpressure();
    pulse_start(2'b00);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    repeat (6) begin
      in_bit = 1'($urandom_range(1));
      cycle();
    end
    #1;
    n_cmp += 3;
    if (sent_q.size() != 2) begin n_err++; $display("FAIL bp accepted: got %0d, want 2", sent_q.size()); end
    if (in_ready !== 1'b0)  begin n_err++; $display("FAIL bp in_ready: got %b, want 0", in_ready); end
    if (busy !== 1'b1)      begin n_err++; $display("FAIL bp busy: got %b, want 1", busy); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) cycle();
    out_ready = 1'b0;
    build_expected(2'b00);
    n_cmp += 3;
    if (got_q.size() != 4)   begin n_err++; $display("FAIL bp drained: got %0d, want 4", got_q.size()); end
    if (out_valid !== 1'b0)  begin n_err++; $display("FAIL bp empty: out_valid %b, want 0", out_valid); end
    if (out_count !== 16'd4) begin n_err++; $display("FAIL bp out_count: got %0d, want 4", out_count); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp bit %0d: got %b, want %b", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_start_mid();
    bit [3:0] g34;
    g34 = 4'b1101;
    pulse_start(2'b00);
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    out_ready = 1'b0;
    repeat (2) cycle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    start     = 1'b1;
    rate      = 2'b10;
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    out_ready = 1'b1;
    #1;
    n_cmp += 2;
    if (busy !== 1'b1)     begin n_err++; $display("FAIL start-mid prefill busy: got %b, want 1", busy); end
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL start-mid in_ready: got %b, want 0", in_ready); end
    @(posedge clk);
    #1;
    start     = 1'b0;
    rate      = 2'b00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_cmp += 3;
    if (out_valid !== 1'b0)  begin n_err++; $display("FAIL start-mid out_valid: got %b, want 0", out_valid); end
    if (busy !== 1'b0)       begin n_err++; $display("FAIL start-mid busy: got %b, want 0", busy); end
    if (out_count !== 16'd0) begin n_err++; $display("FAIL start-mid out_count: got %0d, want 0", out_count); end
    sent_q.delete();
    got_q.delete();
    src_q = '{1'b1, 1'b0, 1'b0};
    drive(4, 100, 100, "start-mid");
    n_cmp++;
    if (got_q.size() != 4) begin n_err++; $display("FAIL start-mid length: got %0d, want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== g34[3-i]) begin n_err++; $display("FAIL start-mid bit %0d: got %b, want %b", i, got_q[i], g34[3-i]); end
    end
  endtask

  task automatic test_async_rst();
    pulse_start(2'b01);
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    out_ready = 1'b0;
    repeat (2) cycle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_cmp += 5;
    if (out_valid !== 1'b0)  begin n_err++; $display("FAIL async-rst out_valid: got %b, want 0", out_valid); end
    if (out_bit !== 1'b0)    begin n_err++; $display("FAIL async-rst out_bit: got %b, want 0", out_bit); end
    if (busy !== 1'b0)       begin n_err++; $display("FAIL async-rst busy: got %b, want 0", busy); end
    if (in_ready !== 1'b0)   begin n_err++; $display("FAIL async-rst in_ready: got %b, want 0", in_ready); end
    if (out_count !== 16'd0) begin n_err++; $display("FAIL async-rst out_count: got %0d, want 0", out_count); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    sent_q.delete();
    got_q.delete();
    for (int i = 0; i < 8; i++) src_q.push_back(1'b0);
    drive(16, 90, 90, "async-rst");
    n_cmp += 2;
    if (got_q.size() != 16)   begin n_err++; $display("FAIL async-rst length: got %0d, want 16", got_q.size()); end
    if (out_count !== 16'd16) begin n_err++; $display("FAIL async-rst out_count: got %0d, want 16", out_count); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== 1'b0) begin n_err++; $display("FAIL async-rst bit %0d: got %b, want 0", i, got_q[i]); end
    end
  endtask

  task automatic test_random();
    int exp_cnt;
    for (int r = 0; r < 4; r++) begin
      exp_cnt = (r == 1) ? 1500 : (r == 2) ? 1334 : 2000;
      pulse_start(2'(r));
      for (int i = 0; i < 1000; i++) src_q.push_back(1'($urandom_range(1)));
      drive(exp_cnt, 80, 70, "random");
      build_expected(2'(r));
      n_cmp += 2;
      if (got_q.size() != exp_q.size()) begin
        n_err++; $display("FAIL random rate %0d length: got %0d, want %0d", r, got_q.size(), exp_q.size());
      end
      if (out_count !== 16'(exp_cnt)) begin
        n_err++; $display("FAIL random rate %0d out_count: got %0d, want %0d", r, out_count, exp_cnt);
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL random rate %0d bit %0d: got %b, want %b", r, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    rate      = 2'b00;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_impulse();
    test_punct();
    test_backpressure();
    test_start_mid();
    test_async_rst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
